mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus (we / a / wd / rd), placed downstream of the CPU beside dmem.
- Software stores bytes to a TXDATA register. The bytes queue in a small FIFO and are serialised 8N1, LSB first, on `tx`.
- STATUS and BAUDDIV registers allow polling and rate control.
- The top level muxes `rd` with dmem using `sel`.

Parameters:
- BASE_ADDR, 32'hFFFFFF00, register window base; 16-byte aligned.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
- CLKS_PER_BIT, 16, reset value of BAUDDIV.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  CPU store strobe (mem_write).
- a  input  32  CPU data address.
- wd  input  32  CPU store data.
- rd  output  32  read data; combinational from `a`.
- sel  output  1  combinational; 1 when a[31:4] == BASE_ADDR[31:4].
- tx  output  1  serial line; idle high.
- tx_idle  output  1  1 when FIFO is empty and the serialiser is in IDLE.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Register map (offset = a[3:2]), word access only, a[1:0] ignored:
  - 0 TXDATA: write pushes wd[7:0]; reads 0.
  - 1 STATUS (read):
    - bit0 full, bit1 empty, bit2 busy (state != IDLE), bit3 overflow (sticky).
    - bits[11:8] FIFO count; all other bits 0.
  - 1 STATUS (write): a 1 in wd[3] clears overflow; other bits ignored.
  - 2 BAUDDIV: R/W, 16 bits in [15:0], upper bits read 0.
  - 3: reserved; reads 0, writes ignored.
- Read path: rd = 0 when sel = 0. No read side effects.
- Writes take effect on the posedge where we & sel.
- Reset:
  - tx = 1, tx_idle = 1.
  - FIFO emptied, count = 0, overflow = 0.
  - BAUDDIV = CLKS_PER_BIT, state = IDLE.
  - Reset mid-frame aborts the frame: tx is 1 from the next edge.
- FIFO:
  - Push while full drops the byte and sets overflow, unless a pop occurs on the same edge; in that case the push is accepted and overflow stays unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is 0..FIFO_DEPTH and needs log2(FIFO_DEPTH)+1 bits.
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register, latch div = max(BAUDDIV, 2), and go to START.
  - START: tx = 0 for div cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for div cycles per bit, shift right; after bit 7 go to STOP.
  - STOP: tx = 1 for div cycles. At the end, if the FIFO is non-empty, pop, latch div and go directly to START (no gap); otherwise go to IDLE.
- Latency: a store to TXDATA at edge N with FIFO empty and state IDLE → pop at N+1; tx low from N+1.
- Frame length is exactly 10*div cycles.
- A BAUDDIV write mid-frame does not affect the current frame; it applies from the next frame.
- Bit counter and divider counter reset at every state entry.
- tx is driven from a register, so it is glitch-free.

Decomposition:
- Package mmio_pkg holds:
  - register offsets (OFF_TXDATA=0, OFF_STATUS=1, OFF_BAUD=2);
  - STATUS bit indices;
  - uart_state_t enum (IDLE, START, DATA, STOP);
  - MIN_DIV=2.
- Sub-module sync_fifo (params WIDTH=8, DEPTH):
  - inputs push, pop, din;
  - outputs dout, full, empty, count.
- The top level holds address decode, registers and the FSM.

Test Plan:
- Reset, then read offsets 0/1/2 → rd = 0 / 32'h00000002 / 32'h00000010; tx = 1, tx_idle = 1; a = 32'h00001000 → sel = 0, rd = 0.
- BAUDDIV := 4, store 8'hA5 → tx low from the next cycle for 4 cycles, then 1,0,1,0,0,1,0,1 (LSB first, 4 cycles each), then high for 4; total 40 cycles; tx_idle returns 1.
- Store 8'h55 then 8'h0F back-to-back (div 4) → two contiguous 40-cycle frames with no idle cycle between; STATUS busy = 1 throughout.
- Store 9 bytes in 9 consecutive cycles, div 16 → the first byte pops immediately, bytes 2-9 fill the FIFO, count = 8, full = 1, overflow = 0. A 10th store sets overflow = 1 and the byte is lost. Writing STATUS wd = 32'h8 clears overflow.
- BAUDDIV := 0 → frame = 20 cycles (clamped to 2). Writing BAUDDIV := 8 mid-frame → current frame unchanged; the next frame is 80 cycles.
- Assert reset during DATA of a frame with 3 bytes queued → tx = 1 from the next edge, count = 0, state IDLE, no further transmission.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout, serialiser states and the baud-divider floor.
package mmio_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    localparam int STS_FULL    = 0;
    localparam int STS_EMPTY   = 1;
    localparam int STS_BUSY    = 2;
    localparam int STS_OVF     = 3;
    localparam int STS_CNT_LSB = 8;
    localparam int STS_CNT_W   = 4;

    localparam logic [15:0] MIN_DIV = 16'd2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // A divider below MIN_DIV would collapse the per-bit counter.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only
// when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; only pointers and
    // count define validity, which keeps it mappable to plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and a
// registered-output serialiser that streams frames back to back.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFFFF00,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx,
    output logic        tx_idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    off;
    logic          wr_en;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   cnt_ext;
    logic [31:0]   status;
    logic          overflow;
    logic [15:0]   baud;

    uart_state_t   state, state_n;
    logic [15:0]   div_q, div_n;
    logic [15:0]   cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n;
    logic          unused_bits;

    assign sel   = (a[31:4] == BASE_ADDR[31:4]);
    assign off   = a[3:2];
    assign wr_en = we & sel;
    assign push  = wr_en & (off == OFF_TXDATA);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (wd[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Overflow is sticky; a full-FIFO push rescued by a same-edge pop is not lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            baud     <= 16'(CLKS_PER_BIT);
        end else begin
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (wr_en && off == OFF_STATUS && wd[STS_OVF])
                overflow <= 1'b0;
            if (wr_en && off == OFF_BAUD)
                baud <= wd[15:0];
        end
    end

    assign cnt_ext = 32'(count);

    always_comb begin
        status                               = '0;
        status[STS_FULL]                     = full;
        status[STS_EMPTY]                    = empty;
        status[STS_BUSY]                     = (state != IDLE);
        status[STS_OVF]                      = overflow;
        status[STS_CNT_LSB +: STS_CNT_W]     = cnt_ext[STS_CNT_W-1:0];
    end

    always_comb begin
        rd = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: rd = status;
                OFF_BAUD:   rd = {16'h0000, baud};
                default:    rd = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            div_q   <= MIN_DIV;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            div_q   <= div_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
        end
    end

    // tx_n is the line level for the state being entered, so tx stays registered.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_n = state;
        div_n   = div_q;
        cnt_n   = cnt + 16'd1;
        bit_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx_q;
        pop     = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    div_n   = clamp_div(baud);
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (cnt == div_q - 16'd1) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = DATA;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (cnt == div_q - 16'd1) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        tx_n    = shift[1];
                    end
                end
            end
            STOP: begin
                if (cnt == div_q - 16'd1) begin
                    cnt_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        div_n   = clamp_div(baud);
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign tx      = tx_q;
    assign tx_idle = empty & (state == IDLE);

    assign unused_bits = ^{a[1:0], wd[31:16], cnt_ext[31:STS_CNT_W]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a per-cycle line monitor compares every
// frame against a queue of expected (byte, divider, back-to-back) entries.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFFFF00;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
    } frame_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [31:0] a     = 32'h0;
    logic [31:0] wd    = 32'h0;
    logic [31:0] rd;
    logic        sel;
    logic        tx;
    logic        tx_idle;

    int     checks   = 0;
    int     failures = 0;
    frame_t exp_q[$];
    bit     in_frame  = 1'b0;
    bit     mon_abort = 1'b0;
    int     ncyc      = 0;
    int     last_end  = -100;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .FIFO_DEPTH   (8),
        .CLKS_PER_BIT (16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .we      (we),
        .a       (a),
        .wd      (wd),
        .rd      (rd),
        .sel     (sel),
        .tx      (tx),
        .tx_idle (tx_idle)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input frame_t f, input int pos);
        int idx;
        idx = pos / f.div;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return f.data[idx-1];
    endfunction

    // Line monitor: samples tx on every falling edge.
    initial begin : monitor
        frame_t cur;
        int     pos;
        int     bad;
        forever begin
            @(negedge clock);
            ncyc++;
            if (mon_abort) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur      = exp_q.pop_front();
                        pos      = 0;
                        bad      = 0;
                        in_frame = 1'b1;
                        if (cur.b2b) check("b2b_start", ncyc, last_end + 1);
                    end
                end
                if (in_frame) begin
                    if (tx !== exp_bit(cur, pos)) bad++;
                    pos++;
                    if (pos == 10 * cur.div) begin
                        check($sformatf("frame_%h_div%0d", cur.data, cur.div), bad, 0);
                        last_end = ncyc;
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic write_reg(input logic [1:0] off, input logic [31:0] data);
        @(negedge clock);
        we = 1'b1;
        a  = BASE | {28'h0, off, 2'b00};
        wd = data;
        @(posedge clock);
        #1;
        we = 1'b0;
    endtask

    task automatic store(input logic [7:0] b, input int div, input bit b2b);
        frame_t f;
        f.data = b;
        f.div  = div;
        f.b2b  = b2b;
        exp_q.push_back(f);
        write_reg(2'd0, {24'h0, b});
    endtask

    task automatic read_check(input logic [1:0] off, input logic [31:0] exp, input string tag);
        @(negedge clock);
        we = 1'b0;
        a  = BASE | {28'h0, off, 2'b00};
        #1;
        check(tag, rd, exp);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(tx_idle === 1'b1 && !in_frame && exp_q.size() == 0) && n < budget) begin
            @(posedge clock);
            #2;
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin : stimulus
        int busy_bad;
        int high_cnt;

        // Reset state and decode
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        read_check(2'd0, 32'h0000_0000, "rst_txdata");
        read_check(2'd1, 32'h0000_0002, "rst_status");
        read_check(2'd2, 32'h0000_0010, "rst_baud");
        read_check(2'd3, 32'h0000_0000, "rst_reserved");
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_idle", 32'(tx_idle), 32'd1);
        @(negedge clock);
        a = 32'h0000_1000;
        #1;
        check("nosel_sel", 32'(sel), 32'd0);
        check("nosel_rd", rd, 32'h0);

        // Single frame, div 4, with first-cycle latency
        write_reg(2'd2, 32'd4);
        read_check(2'd2, 32'd4, "baud_rb4");
        store(8'hA5, 4, 1'b0);
        @(negedge clock);
        check("lat_tx_before", 32'(tx), 32'd1);
        check("lat_not_idle", 32'(tx_idle), 32'd0);
        @(negedge clock);
        check("lat_tx_low", 32'(tx), 32'd0);
        wait_idle(200, "idle_after_a5");
        check("tx_idle_a5", 32'(tx_idle), 32'd1);

        // Back-to-back frames, busy held throughout
        store(8'h55, 4, 1'b0);
        store(8'h0F, 4, 1'b1);
        busy_bad = 0;
        for (int i = 0; i < 78; i++) begin
            @(negedge clock);
            a = BASE | 32'h4;
            #1;
            if (rd[2] !== 1'b1) busy_bad++;
        end
        check("busy_throughout", busy_bad, 0);
        wait_idle(300, "idle_after_b2b");

        // Fill, overflow and overflow clear at div 16
        write_reg(2'd2, 32'd16);
        store(8'h11, 16, 1'b0);
        for (int k = 2; k <= 9; k++) store(8'(8'h11 * k), 16, 1'b1);
        read_check(2'd1, 32'h0000_0805, "status_full");
        write_reg(2'd0, 32'h0000_00EE);
        read_check(2'd1, 32'h0000_080D, "status_ovf");
        write_reg(2'd1, 32'h0000_0008);
        read_check(2'd1, 32'h0000_0805, "status_ovf_clr");
        wait_idle(2500, "idle_after_fill");
        read_check(2'd1, 32'h0000_0002, "status_drained");

        // Divider clamp and mid-frame divider change
        write_reg(2'd2, 32'd0);
        read_check(2'd2, 32'd0, "baud_rb0");
        store(8'h3C, 2, 1'b0);
        write_reg(2'd2, 32'd8);
        store(8'hC3, 8, 1'b1);
        read_check(2'd2, 32'd8, "baud_rb8");
        wait_idle(300, "idle_after_clamp");

        // Reset during DATA with three bytes queued
        write_reg(2'd2, 32'd4);
        store(8'h00, 4, 1'b0);
        store(8'h81, 4, 1'b1);
        store(8'h42, 4, 1'b1);
        store(8'h24, 4, 1'b1);
        read_check(2'd1, 32'h0000_0304, "status_q3");
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("mid_data_tx_low", 32'(tx), 32'd0);
        @(posedge clock);
        #1;
        mon_abort = 1'b1;
        reset     = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort_tx_high", 32'(tx), 32'd1);
        check("abort_tx_idle", 32'(tx_idle), 32'd1);
        read_check(2'd1, 32'h0000_0002, "abort_status");
        read_check(2'd2, 32'h0000_0010, "abort_baud");
        exp_q.delete();
        @(posedge clock);
        #1 mon_abort = 1'b0;
        high_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (tx === 1'b1) high_cnt++;
        end
        check("abort_no_tx", high_cnt, 300);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
